// File: rtl/iiitb_imem_loader.sv
// Byte-stream program loader: parses a length-prefixed, XOR-checksummed image,
// writes it into instruction memory and releases the core once it verifies.
//
// state  | meaning
// LEN_HI | waiting for upper byte of the word count
// LEN_LO | waiting for lower byte; range-checks the count
// DATA   | assembling 4-byte words, one MEM write per word
// CSUM   | comparing the trailing byte with the running XOR
// DONE   | image verified, core running
// ERROR  | overflow or checksum mismatch, core held
module iiitb_imem_loader #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              RN,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              load_start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_run,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR
  } state_t;

  localparam logic [16:0]       LEN_MAX = 17'((2 ** ADDR_W) - BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [7:0]  csum;
  logic [23:0] asm_q;
  logic [1:0]  byte_cnt;

  logic [15:0] len_next;
  logic [ADDR_W:0] wl_next;
  logic [7:0]  csum_next;

  always_comb begin
    len_next  = {len_hi, in_data};
    wl_next   = words_loaded + (ADDR_W+1)'(1);
    csum_next = csum ^ in_data;
  end

  always_ff @(posedge clk) begin
    if (!RN) begin
      state        <= LEN_HI;
      len_hi       <= '0;
      len          <= '0;
      csum         <= '0;
      asm_q        <= '0;
      byte_cnt     <= '0;
      in_ready     <= 1'b1;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      core_run     <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        LEN_HI: begin
          if (in_valid) begin
            len_hi <= in_data;
            csum   <= csum_next;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (in_valid) begin
            len  <= len_next;
            csum <= csum_next;
            if ({1'b0, len_next} > LEN_MAX) begin
              state    <= ERROR;
              in_ready <= 1'b0;
              load_err <= 1'b1;
            end else if (len_next == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (in_valid) begin
            asm_q    <= {asm_q[15:0], in_data};
            byte_cnt <= byte_cnt + 2'd1;
            csum     <= csum_next;
            if (byte_cnt == 2'd3) begin
              mem_we       <= 1'b1;
              mem_wdata    <= {asm_q, in_data};
              mem_addr     <= BASE + words_loaded[ADDR_W-1:0];
              words_loaded <= wl_next;
              if (16'(wl_next) == len) state <= CSUM;
            end
          end
        end
        CSUM: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state     <= DONE;
              load_done <= 1'b1;
              core_run  <= 1'b1;
            end else begin
              state    <= ERROR;
              load_err <= 1'b1;
            end
          end
        end
        DONE, ERROR: begin
          if (load_start) begin
            state        <= LEN_HI;
            in_ready     <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            core_run     <= 1'b0;
            words_loaded <= '0;
            csum         <= '0;
            asm_q        <= '0;
            byte_cnt     <= '0;
          end
        end
        default: state <= LEN_HI;
      endcase
    end
  end

endmodule

// File: doc/iiitb_imem_loader.md
Name: iiitb_imem_loader

Overview:
Byte-stream program loader that writes instruction words into the rv32i core's instruction memory (MEM) through a write port. It holds the core in reset until a complete, checksum-verified image is written. It is the hardware writer-side counterpart to the core's instruction fetch, and replaces backdoor memory preloading for silicon and FPGA bring-up. It sits between a byte source (UART receiver or debug bridge) and the MEM write port, and drives the core's run enable.

Parameters:
ADDR_W, 6, MEM word-address width; depth = 2^ADDR_W words (64).
BASE_ADDR, 0, first MEM word address written.

Ports:
clk  input  1  system clock, rising edge.
RN  input  1  synchronous active-low reset.
in_valid  input  1  byte source has valid data.
in_data  input  8  byte from the source.
in_ready  output  1  loader accepts a byte this cycle.
load_start  input  1  single-cycle pulse; restarts loading from DONE or ERROR.
mem_we  output  1  MEM write strobe, one cycle per word.
mem_addr  output  ADDR_W  MEM word address.
mem_wdata  output  32  instruction word.
core_run  output  1  1 = core released from reset and fetching.
load_done  output  1  image loaded and checksum verified.
load_err  output  1  length overflow or checksum mismatch.
words_loaded  output  ADDR_W+1  count of words written in the current load.

Behaviour:
- Reset, sampled on the clk edge with RN=0: state=LEN_HI. All outputs 0 except in_ready=1. Internal count, length and checksum cleared. Reset during any state aborts the load. Words already written stay in MEM; core_run=0.
- A byte transfer occurs on a clk edge with in_valid=1 and in_ready=1. in_ready=1 in LEN_HI, LEN_LO, DATA and CSUM, and 0 in DONE and ERROR. There are no stalls inside a load.
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N words of 4 bytes each, MSB first, then one checksum byte. The checksum is the XOR of every preceding frame byte, header included.
- FSM:
  - LEN_HI: take the byte as the upper length byte -> LEN_LO.
  - LEN_LO: form N.
    - If N > 2^ADDR_W - BASE_ADDR -> ERROR.
    - Else if N = 0 -> CSUM.
    - Else -> DATA.
  - DATA: shift bytes into a 32-bit assembler. When the 4th byte is accepted, the next cycle has mem_we=1, mem_wdata=word, mem_addr=BASE_ADDR+index, and words_loaded increments on that same edge. After word N is accepted -> CSUM.
  - CSUM: compare the received byte with the running XOR. Match -> DONE. Mismatch -> ERROR.
  - DONE: load_done=1, core_run=1. On load_start=1 -> LEN_HI.
  - ERROR: load_err=1, core_run=0. On load_start=1 -> LEN_HI.
- On entering LEN_HI via load_start: load_done, load_err, core_run, words_loaded, the checksum and the assembler are all cleared.
- load_start is ignored in LEN_HI, LEN_LO, DATA and CSUM.
- Write latency: mem_we asserts exactly 1 cycle after the 4th byte of a word is accepted. Back-to-back bytes therefore give at most 1 write every 4 cycles.
- mem_we is 0 in all other cycles. mem_addr and mem_wdata hold their last values when mem_we=0.
- Address arithmetic is ADDR_W-bit. The length check guarantees no wrap, so a write past the top word never occurs.
- The last-word write and the CSUM byte may coincide in the same cycle. Both are handled; the write is not lost.
- in_valid=0 gaps of any length inside a frame are permitted. The state is held.

Test Plan:
- Nominal load: RN low for 2 cycles, then stream 00 03 00 22 20 00 04 43 28 00 10 E6 00 01 99. Required: MEM[0..2]=00222000, 04432800, 10E60001; mem_we pulses 3 times, each 1 cycle after byte 6, 10 and 14; words_loaded=3; load_done=1 and core_run=1 on the cycle after the 0x99 byte.
- Bad checksum: same stream ending in 0x98. Required: 3 writes still occur, load_err=1, core_run=0, in_ready=0. A load_start pulse then clears load_err and sets in_ready=1.
- Overflow: stream 00 41 with ADDR_W=6. Required: ERROR immediately after byte 2, with no mem_we. Stream 00 40 plus 256 bytes plus a correct checksum is accepted, with the last write to address 63.
- Zero length: stream 00 00 00. Required: DONE, no writes, words_loaded=0.
- Gaps and reset: insert random in_valid=0 gaps (1-5 cycles) in the nominal stream; the result must be identical. Separately, assert RN low after byte 8. Required: core_run=0, state LEN_HI, and a fresh nominal stream then loads correctly.
- Reload: after DONE, pulse load_start and send 00 01 01 AE 60 00 CE with BASE_ADDR=47. Required: MEM[47]=01AE6000, core_run=0 during the load and 1 after it completes.
